// File: rtl/branch_hazard_ctrl.sv
// Branch / load-use hazard controller with multi-cycle flush and stall windows.
// Optional taken-branch statistics counter enabled by defining BRANCH_STAT_EN.
module branch_hazard_ctrl #(
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned STALL_CYC = 1,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned STAT_W    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pc_src,
    input  logic       load_use,
    output logic       en_pc,
    output logic       en_if,
    output logic       flush,
    output logic       bubble,
    output logic [2:0] en_branch,
    output logic       busy
`ifdef BRANCH_STAT_EN
    ,
    output logic [STAT_W-1:0] br_count
`endif
);

    typedef enum logic [1:0] {StIdle, StFlush, StStall} state_e;

    localparam logic [CNT_W-1:0] FlushLoad = CNT_W'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] StallLoad = CNT_W'(STALL_CYC - 1);

    if (FLUSH_CYC < 1 || FLUSH_CYC > 15 || STALL_CYC < 1 || STALL_CYC > 15 || STAT_W < 1 ||
        (FLUSH_CYC >> CNT_W) != 0 || (STALL_CYC >> CNT_W) != 0) begin : g_bad_params
        $error("branch_hazard_ctrl: parameter out of range");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             take_br, take_st, hold_st;
    logic             flush_c, bubble_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        // A branch in STALL is older than the stalled load consumer, so it wins.
        take_br  = pc_src && (state_q != StFlush);
        take_st  = load_use && !pc_src && (state_q == StIdle);
        hold_st  = (state_q == StStall) && !pc_src;
        flush_c  = take_br || (state_q == StFlush);
        bubble_c = take_st || hold_st;

        if (take_br) begin
            if (FLUSH_CYC > 1) begin
                state_d = StFlush;
                cnt_d   = FlushLoad;
            end else begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        end else if (take_st) begin
            if (STALL_CYC > 1) begin
                state_d = StStall;
                cnt_d   = StallLoad;
            end else begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        end else if (state_q != StIdle) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Gating with rst keeps outputs low (and X-free) for the whole reset window.
    assign en_pc     = rst & ~bubble_c;
    assign en_if     = rst & ~bubble_c;
    assign flush     = rst & flush_c;
    assign bubble    = rst & bubble_c;
    assign busy      = rst & (state_q != StIdle);
    assign en_branch = {en_if, flush, en_pc};

`ifdef BRANCH_STAT_EN
    logic [STAT_W-1:0] br_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt_q <= '0;
        end else if (take_br && (br_cnt_q != {STAT_W{1'b1}})) begin
            br_cnt_q <= br_cnt_q + STAT_W'(1);
        end
    end

    assign br_count = br_cnt_q;
`endif

endmodule
